// File: rtl/sa8_feeder_if.sv
// rtl/sa8_feeder_if.sv - handshake and skewed-output bundle between tile source, feeder and array
interface sa8_feeder_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [7:0]           k_len;
    logic                 in_valid;
    logic                 in_ready;
    logic [8*WIDTH-1:0]   in_act;
    logic [8*WIDTH-1:0]   in_wgt;
    logic [8*WIDTH-1:0]   activation;
    logic [8*WIDTH-1:0]   weight;
    logic                 control;
    logic                 busy;
    logic                 done;

    modport master (
        output start, k_len, in_valid, in_act, in_wgt,
        input  in_ready, activation, weight, control, busy, done
    );

    modport slave (
        input  start, k_len, in_valid, in_act, in_wgt,
        output in_ready, activation, weight, control, busy, done
    );
endinterface

// File: rtl/sa8_feeder.sv
// rtl/sa8_feeder.sv - 8-lane diagonal skew feeder for an 8x8 systolic array, one tile per start
module sa8_feeder #(
    parameter int WIDTH     = 8,
    parameter int FLUSH_CYC = 22
) (
    input  logic          clk,
    input  logic          rst,
    sa8_feeder_if.slave   bus
);
    localparam int LANES = 8;
    localparam int VW    = LANES * WIDTH;
    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [7:0]      k_lat;
    logic [7:0]      beat_cnt;
    logic [7:0]      flush_cnt;
    logic            accept;
    logic            done_nxt;
    logic [VW-1:0]   act_in0;
    logic [VW-1:0]   wgt_in0;
    logic [VW-1:0]   act_skew;
    logic [VW-1:0]   wgt_skew;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = (bus.k_len != 8'd0) ? FEED : DONE;
                end
            end
            FEED: begin
                if (accept && (beat_cnt == k_lat - 8'd1)) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt == FLUSH_LAST) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // in_ready decodes the state register only, so in_valid never reaches it
    always_comb begin
        bus.in_ready = (state == FEED);
        bus.busy     = (state != IDLE);
        accept       = (state == FEED) && bus.in_valid;
        done_nxt     = (next_state == DONE);
        act_in0      = accept ? bus.in_act : '0;
        wgt_in0      = accept ? bus.in_wgt : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_lat     <= 8'd0;
            beat_cnt  <= 8'd0;
            flush_cnt <= 8'd0;
        end else begin
            if (state == IDLE && bus.start) begin
                k_lat    <= bus.k_len;
                beat_cnt <= 8'd0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            flush_cnt <= (state == FLUSH) ? flush_cnt + 8'd1 : 8'd0;
        end
    end

    // Lane i holds 1+i stages; bubbles travel the same pipes so beats never merge
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int HI = VW - 1 - WIDTH * i;
        logic [WIDTH-1:0] act_pipe [0:i];
        logic [WIDTH-1:0] wgt_pipe [0:i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    act_pipe[j] <= '0;
                    wgt_pipe[j] <= '0;
                end
            end else begin
                act_pipe[0] <= act_in0[HI -: WIDTH];
                wgt_pipe[0] <= wgt_in0[HI -: WIDTH];
                for (int j = 1; j <= i; j++) begin
                    act_pipe[j] <= act_pipe[j-1];
                    wgt_pipe[j] <= wgt_pipe[j-1];
                end
            end
        end

        assign act_skew[HI -: WIDTH] = act_pipe[i];
        assign wgt_skew[HI -: WIDTH] = wgt_pipe[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.activation <= '0;
            bus.weight     <= '0;
            bus.done       <= 1'b0;
            bus.control    <= 1'b0;
        end else begin
            bus.activation <= act_skew;
            bus.weight     <= wgt_skew;
            bus.done       <= done_nxt;
            bus.control    <= done_nxt;
        end
    end
endmodule

// File: tb/tb_sa8_feeder.sv
// tb/tb_sa8_feeder.sv - directed self-checking bench for sa8_feeder
module tb_sa8_feeder;
    logic clk = 1'b0;
    logic rst;
    int   ck = 0;
    int   er = 0;

    sa8_feeder_if #(.WIDTH(8)) bus ();

    sa8_feeder #(.WIDTH(8), .FLUSH_CYC(22)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] put_lane(logic [63:0] v, int i, logic [7:0] b);
        v[63-8*i -: 8] = b;
        return v;
    endfunction

    task automatic wait_idle(string name);
        int n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        ck++;
        if (bus.busy !== 1'b0) begin
            er++;
            $display("FAIL %s_idle busy=%b required 0", name, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        ck++; if (bus.activation !== 64'h0) begin er++; $display("FAIL rst_act got %h required 0", bus.activation); end
        ck++; if (bus.weight !== 64'h0) begin er++; $display("FAIL rst_wgt got %h required 0", bus.weight); end
        ck++; if (bus.control !== 1'b0) begin er++; $display("FAIL rst_control got %b required 0", bus.control); end
        ck++; if (bus.done !== 1'b0) begin er++; $display("FAIL rst_done got %b required 0", bus.done); end
        ck++; if (bus.busy !== 1'b0) begin er++; $display("FAIL rst_busy got %b required 0", bus.busy); end
        ck++; if (bus.in_ready !== 1'b0) begin er++; $display("FAIL rst_ready got %b required 0", bus.in_ready); end
        rst = 1'b0;
        @(negedge clk);
        ck++; if (bus.busy !== 1'b0) begin er++; $display("FAIL rst_rel_busy got %b required 0", bus.busy); end
    endtask

    task automatic test_skew();
        logic [63:0] ea, ew;
        int m;
        bus.start = 1'b1; bus.k_len = 8'd1;
        @(negedge clk);
        ck++; if (bus.in_ready !== 1'b1) begin er++; $display("FAIL skew_ready got %b required 1", bus.in_ready); end
        bus.start = 1'b0; bus.in_valid = 1'b1;
        bus.in_act = 64'h0102030405060708;
        bus.in_wgt = 64'h1112131415161718;
        for (int j = 2; j <= 11; j++) begin
            @(negedge clk);
            m = j - 2;
            ea = 64'h0; ew = 64'h0;
            if (m >= 1 && m <= 8) begin
                ea = put_lane(ea, m - 1, 8'(m));
                ew = put_lane(ew, m - 1, 8'(8'h10 + m));
            end
            ck++; if (bus.activation !== ea) begin er++; $display("FAIL skew_act m=%0d got %h required %h", m, bus.activation, ea); end
            ck++; if (bus.weight !== ew) begin er++; $display("FAIL skew_wgt m=%0d got %h required %h", m, bus.weight, ew); end
            if (j == 2) begin
                bus.in_valid = 1'b0; bus.in_act = '1; bus.in_wgt = '1;
            end
        end
        wait_idle("skew");
        bus.in_act = '0; bus.in_wgt = '0;
    endtask

    task automatic test_full_tile();
        int rc = 0, first = 0, last = 0, dc = 0, dcyc = 0, cc = 0, ccyc = 0;
        logic busy31, busy32;
        bus.start = 1'b1; bus.k_len = 8'd8; bus.in_valid = 1'b1;
        bus.in_act = 64'hDEADBEEFCAFEF00D; bus.in_wgt = 64'h0123456789ABCDEF;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin rc++; if (first == 0) first = c; last = c; end
            if (bus.done) begin dc++; dcyc = c; end
            if (bus.control) begin cc++; ccyc = c; end
            if (c == 31) busy31 = bus.busy;
            if (c == 32) busy32 = bus.busy;
            if (c == 1) bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
        ck++; if (rc != 8) begin er++; $display("FAIL full_ready_cnt got %0d required 8", rc); end
        ck++; if (first != 1 || last != 8) begin er++; $display("FAIL full_ready_window got %0d..%0d required 1..8", first, last); end
        ck++; if (dc != 1 || dcyc != 31) begin er++; $display("FAIL full_done got %0d pulses at %0d required 1 at 31", dc, dcyc); end
        ck++; if (cc != 1 || ccyc != 31) begin er++; $display("FAIL full_control got %0d pulses at %0d required 1 at 31", cc, ccyc); end
        ck++; if (busy31 !== 1'b1 || busy32 !== 1'b0) begin er++; $display("FAIL full_busy got %b%b required 10", busy31, busy32); end
    endtask

    task automatic test_bubbles();
        logic [63:0] ea, ew;
        logic [4:0] pat = 5'b10101;
        int rc = 0, m, idx;
        logic [7:0] ba, bw;
        bus.start = 1'b1; bus.k_len = 8'd3;
        for (int j = 1; j <= 17; j++) begin
            @(negedge clk);
            m = j - 2;
            ea = 64'h0; ew = 64'h0;
            for (int i = 0; i < 8; i++) begin
                idx = m - 1 - i;
                ba = (idx == 0) ? 8'hA1 : (idx == 2) ? 8'hB2 : (idx == 4) ? 8'hC3 : 8'h00;
                bw = (idx == 0) ? 8'h1A : (idx == 2) ? 8'h2B : (idx == 4) ? 8'h3C : 8'h00;
                ea = put_lane(ea, i, ba);
                ew = put_lane(ew, i, bw);
            end
            ck++; if (bus.activation !== ea) begin er++; $display("FAIL bub_act j=%0d got %h required %h", j, bus.activation, ea); end
            ck++; if (bus.weight !== ew) begin er++; $display("FAIL bub_wgt j=%0d got %h required %h", j, bus.weight, ew); end
            if (bus.in_ready) rc++;
            bus.start = 1'b0;
            if (j <= 5) begin
                bus.in_valid = pat[5-j];
                case (j)
                    1: begin bus.in_act = {8{8'hA1}}; bus.in_wgt = {8{8'h1A}}; end
                    3: begin bus.in_act = {8{8'hB2}}; bus.in_wgt = {8{8'h2B}}; end
                    5: begin bus.in_act = {8{8'hC3}}; bus.in_wgt = {8{8'h3C}}; end
                    default: begin bus.in_act = '1; bus.in_wgt = '1; end
                endcase
            end else begin
                bus.in_valid = 1'b0; bus.in_act = '0; bus.in_wgt = '0;
            end
        end
        ck++; if (rc != 5) begin er++; $display("FAIL bub_ready_cnt got %0d required 5", rc); end
        wait_idle("bub");
    endtask

    task automatic test_zero_len();
        bus.start = 1'b1; bus.k_len = 8'd0;
        @(negedge clk);
        ck++; if (bus.done !== 1'b1) begin er++; $display("FAIL zero_done got %b required 1", bus.done); end
        ck++; if (bus.control !== 1'b1) begin er++; $display("FAIL zero_control got %b required 1", bus.control); end
        ck++; if (bus.in_ready !== 1'b0) begin er++; $display("FAIL zero_ready got %b required 0", bus.in_ready); end
        bus.start = 1'b0;
        @(negedge clk);
        ck++; if (bus.done !== 1'b0 || bus.control !== 1'b0) begin er++; $display("FAIL zero_after got done=%b ctl=%b required 0 0", bus.done, bus.control); end
        ck++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin er++; $display("FAIL zero_idle got busy=%b ready=%b required 0 0", bus.busy, bus.in_ready); end
    endtask

    task automatic test_busy_start();
        int acc = 0, dc = 0;
        bus.start = 1'b1; bus.k_len = 8'd4; bus.in_valid = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (bus.in_ready && bus.in_valid) acc++;
            if (bus.done) dc++;
            case (c)
                1: bus.start = 1'b0;
                2: begin bus.start = 1'b1; bus.k_len = 8'd5; end
                3: bus.start = 1'b0;
                default: ;
            endcase
        end
        bus.in_valid = 1'b0;
        ck++; if (acc != 4) begin er++; $display("FAIL busy_start_beats got %0d required 4", acc); end
        ck++; if (dc != 1) begin er++; $display("FAIL busy_start_done got %0d required 1", dc); end
    endtask

    task automatic test_reset_mid();
        int dc = 0;
        bus.start = 1'b1; bus.k_len = 8'd8; bus.in_valid = 1'b1;
        bus.in_act = {8{8'h11}}; bus.in_wgt = {8{8'h22}};
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        ck++; if (bus.activation === 64'h0) begin er++; $display("FAIL mid_pre_act got %h required nonzero", bus.activation); end
        #2 rst = 1'b1;
        #1;
        ck++; if (bus.activation !== 64'h0 || bus.weight !== 64'h0) begin er++; $display("FAIL mid_rst_data got %h %h required 0 0", bus.activation, bus.weight); end
        ck++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin er++; $display("FAIL mid_rst_state got busy=%b ready=%b required 0 0", bus.busy, bus.in_ready); end
        ck++; if (bus.done !== 1'b0 || bus.control !== 1'b0) begin er++; $display("FAIL mid_rst_ctl got done=%b ctl=%b required 0 0", bus.done, bus.control); end
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.start = 1'b1; bus.k_len = 8'd1;
        @(negedge clk);
        ck++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin er++; $display("FAIL mid_restart got ready=%b busy=%b required 1 1", bus.in_ready, bus.busy); end
        bus.start = 1'b0; bus.in_valid = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.done) dc++;
        end
        ck++; if (dc != 1) begin er++; $display("FAIL mid_done_cnt got %0d required 1", dc); end
        ck++; if (bus.busy !== 1'b0) begin er++; $display("FAIL mid_end_busy got %b required 0", bus.busy); end
        bus.in_act = '0; bus.in_wgt = '0;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.k_len = 8'd0; bus.in_valid = 1'b0;
        bus.in_act = '0; bus.in_wgt = '0;
        test_reset();
        test_skew();
        test_full_tile();
        test_bubbles();
        test_zero_len();
        test_busy_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", ck, er);
        $finish;
    end
endmodule

// File: doc/sa8_feeder.md
SA8_FEEDER -- requirements
Module: sa8_feeder

Interface
REQ-001 Parameter WIDTH, default 8, operand byte width per lane.
REQ-002 Parameter FLUSH_CYC, default 22, zero-drive cycles after last beat (7 skew + 14 array propagation + 1 margin).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin one tile; sampled only in IDLE.
REQ-006 k_len  input  8  tile length in beats, latched on accepted start.
REQ-007 in_valid  input  1  beat present on in_act/in_wgt.
REQ-008 in_ready  output  1  feeder accepts a beat this cycle.
REQ-009 in_act  input  8*WIDTH  unskewed activation vector, lane i at bits [8*WIDTH-1-WIDTH*i -: WIDTH] (lane 0 = MSB byte).
REQ-010 in_wgt  input  8*WIDTH  unskewed weight vector, same lane packing.
REQ-011 activation  output  8*WIDTH  skewed activations to array, same packing.
REQ-012 weight  output  8*WIDTH  skewed weights to array, same packing.
REQ-013 control  output  1  array control; 1 = end-of-tile latch/clear, 0 = accumulate.
REQ-014 busy  output  1  high whenever state != IDLE.
REQ-015 done  output  1  one-cycle pulse at tile completion.

Function
REQ-016 FSM states IDLE, FEED, FLUSH, DONE; one-hot or binary is implementer's choice.
REQ-017 IDLE: start=1 and k_len!=0 -> FEED, k_len latched, beat counter cleared; start=1 and k_len==0 -> DONE, no beats accepted.
REQ-018 in_ready SHALL be 1 exactly in FEED; beat accepted when in_valid & in_ready.
REQ-019 FEED: on acceptance of beat number k_len (counter == latched k_len-1) -> FLUSH, flush counter cleared.
REQ-020 FLUSH: after exactly FLUSH_CYC cycles -> DONE.
REQ-021 DONE: lasts one cycle, done=1, control=1, then -> IDLE.
REQ-022 control SHALL be 0 in IDLE, FEED, FLUSH.
REQ-023 Skew: lane i of both act and wgt passes through 1+i register stages; accepted beat at edge t appears lane 0 on outputs after edge t+1, lane i after edge t+1+i.
REQ-024 Any FEED cycle with in_valid=0, and every IDLE/FLUSH/DONE cycle, SHALL inject an all-zero vector into stage 0 (bubble); skew registers advance every cycle unconditionally, never stall.
REQ-025 Bubbles preserve lane alignment; data of beat n never merges with beat n+1.
REQ-026 start asserted while busy SHALL be ignored; k_len changes while busy SHALL not affect the running tile.
REQ-027 Beat counter and flush counter SHALL not wrap within a tile (k_len max 255, counter 8 bits).
REQ-028 No combinational path from in_valid to in_ready; activation/weight/control/done SHALL be registered.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, all skew stages, activation, weight to 0, control=0, done=0, busy=0, in_ready=0, counters 0.
REQ-030 rst asserted mid-FEED or mid-FLUSH SHALL discard the tile; no done pulse; after rst release feeder accepts a new start next cycle.

Verification
REQ-031 Reset: rst high mid-FEED with nonzero skew contents -> all outputs 0 same cycle, busy=0 after release.
REQ-032 Skew: k_len=1, in_act=0x0102030405060708 at edge t -> activation lane 0 = 0x01 after t+1, lane 7 = 0x08 after t+8, all other cycles lane bytes 0.
REQ-033 Full tile: k_len=8, continuous in_valid -> in_ready high 8 cycles, FLUSH 22 cycles, done and control high exactly one cycle 31 cycles after first beat.
REQ-034 Bubbles: k_len=3, in_valid pattern 1,0,1,0,1 -> 3 beats accepted over 5 FEED cycles, zero vector between beats on every lane at its skewed time.
REQ-035 Zero length: start with k_len=0 -> in_ready never high, done pulse next cycle, control=1 that cycle.
REQ-036 Busy start: second start with k_len=5 during FEED of k_len=4 tile -> ignored, exactly 4 beats accepted, one done pulse.
